// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: async FIFO write-side pointer, synchroniser and full/level/overflow flag controller
module wptr_full_ctrl #(
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic               w_en,
  input  logic [PTR_WIDTH:0] g_rptr,
  input  logic               ovf_clr,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               full,
  output logic               almost_full,
  output logic [PTR_WIDTH:0] wr_level,
  output logic               overflow
);
  localparam int W = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] AF = W'(AF_THRESH);
  logic [SYNC_STAGES-1:0][PTR_WIDTH:0] sync_q;
  logic [PTR_WIDTH:0] g_rptr_s, b_rptr_s, b_wptr_next, g_wptr_next, level_next;
  logic wr_acc;
  assign g_rptr_s = sync_q[SYNC_STAGES-1];
  for (genvar i = 0; i <= PTR_WIDTH; i++) begin : g_dec
    assign b_rptr_s[i] = ^g_rptr_s[PTR_WIDTH:i];
  end
  always_comb begin
    wr_acc      = w_en & ~full;
    b_wptr_next = b_wptr + W'(wr_acc);
    g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;
    level_next  = b_wptr_next - b_rptr_s;
  end
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      sync_q      <= '0;
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], g_rptr};
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      full        <= g_wptr_next == {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]};
      wr_level    <= level_next;
      almost_full <= level_next >= AF;
      overflow    <= (w_en & full) | (overflow & ~ovf_clr);
    end
endmodule
